// File: rtl/agen_issue_arbiter.sv
// Round-robin arbiter sharing the single AGEN unit among NUM_REQ issue slots.
// The winner is held in a one-entry output register until the LSQ takes it.
// Work younger than a mispredicted branch is squashed both in the held slot
// and among incoming requests. Resolved checkpoint bits are cleared in flight.
module agen_issue_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned REQ_LOG     = 2,
  parameter int unsigned CHECKPOINTS = 4,
  parameter int unsigned CKPT_LOG    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*CHECKPOINTS-1:0] reqMask_i,
  input  logic                           lsqReady_i,
  input  logic                           ctrlVerified_i,
  input  logic                           ctrlMispredict_i,
  input  logic [CKPT_LOG-1:0]            ctrlSMTid_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           outValid_o,
  output logic [REQ_LOG-1:0]             outIdx_o,
  output logic [CHECKPOINTS-1:0]         outMask_o
);

  logic [REQ_LOG-1:0]     r_ptr;
  logic                   r_slotValid;
  logic [REQ_LOG-1:0]     r_slotIdx;
  logic [CHECKPOINTS-1:0] r_slotMask;

  logic                   w_kill;
  logic                   w_clr;
  logic [CHECKPOINTS-1:0] w_clrVec;
  logic [CHECKPOINTS-1:0] w_reqMask [NUM_REQ];
  logic [NUM_REQ-1:0]     w_elig;
  logic                   w_slotKill;
  logic                   w_outValid;
  logic                   w_drain;
  logic                   w_accept;
  logic                   w_found;
  logic [REQ_LOG-1:0]     w_winIdx;
  logic [NUM_REQ-1:0]     w_grant;

  assign w_kill = ctrlVerified_i & ctrlMispredict_i;
  assign w_clr  = ctrlVerified_i & ~ctrlMispredict_i;

  // One-hot of the resolved checkpoint bit, only when it resolved correctly.
  always_comb begin
    w_clrVec = '0;
    for (int unsigned c = 0; c < CHECKPOINTS; c++) begin
      w_clrVec[c] = w_clr & (ctrlSMTid_i == CKPT_LOG'(c));
    end
  end

  // Split the packed request masks and drop requests killed by a mispredict.
  always_comb begin
    w_elig = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_reqMask[k] = reqMask_i[k*CHECKPOINTS +: CHECKPOINTS];
      w_elig[k]    = req_i[k] & ~(w_kill & w_reqMask[k][ctrlSMTid_i]);
    end
  end

  // Held-slot squash is same-cycle, so a killed slot frees for a new winner.
  assign w_slotKill = w_kill & r_slotMask[ctrlSMTid_i];
  assign w_outValid = r_slotValid & ~w_slotKill;
  assign w_drain    = w_outValid & lsqReady_i;
  assign w_accept   = ~r_slotValid | w_drain | w_slotKill;

  // Rotating-priority search starting at the pointer; REQ_LOG-bit add wraps.
  always_comb begin
    logic [REQ_LOG-1:0] cand;
    cand     = '0;
    w_found  = 1'b0;
    w_winIdx = '0;
    for (int unsigned o = 0; o < NUM_REQ; o++) begin
      cand = r_ptr + REQ_LOG'(o);
      if (!w_found && w_elig[cand]) begin
        w_found  = 1'b1;
        w_winIdx = cand;
      end
    end
  end

  // Grant only when the output slot can take the op; gated off during reset.
  always_comb begin
    w_grant = '0;
    if (w_accept && w_found && !reset) begin
      w_grant[w_winIdx] = 1'b1;
    end
  end

  assign grant_o    = w_grant;
  assign outValid_o = w_outValid;
  assign outIdx_o   = r_slotIdx;
  assign outMask_o  = r_slotMask;

  // Output slot and round-robin pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_slotValid <= 1'b0;
      r_slotIdx   <= '0;
      r_slotMask  <= '0;
    end else if (w_accept && w_found) begin
      r_slotValid <= 1'b1;
      r_slotIdx   <= w_winIdx;
      r_slotMask  <= w_reqMask[w_winIdx] & ~w_clrVec;
      r_ptr       <= w_winIdx + REQ_LOG'(1);
    end else if (w_accept) begin
      r_slotValid <= 1'b0;
    end else begin
      r_slotMask  <= r_slotMask & ~w_clrVec;
    end
  end

endmodule

// File: tb/tb_agen_issue_arbiter.sv
// Self-checking bench for agen_issue_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the slot.
module tb_agen_issue_arbiter;

  localparam int NR = 4;
  localparam int CK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] rmask;
  logic        lsq;
  logic        ver;
  logic        mis;
  logic [1:0]  sid;
  logic [3:0]  grant_o;
  logic        outValid_o;
  logic [1:0]  outIdx_o;
  logic [3:0]  outMask_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model state and per-cycle expectations.
  int m_ptr, m_idx, m_mask;
  bit m_valid;
  int n_ptr, n_idx, n_mask;
  bit n_valid;
  int e_grant, e_ov, e_idx, e_mask;

  always #5 clk = ~clk;

  agen_issue_arbiter #(
    .NUM_REQ(4), .REQ_LOG(2), .CHECKPOINTS(4), .CKPT_LOG(2)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req), .reqMask_i(rmask),
    .lsqReady_i(lsq), .ctrlVerified_i(ver), .ctrlMispredict_i(mis),
    .ctrlSMTid_i(sid), .grant_o(grant_o), .outValid_o(outValid_o),
    .outIdx_o(outIdx_o), .outMask_o(outMask_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_idx = 0; m_mask = 0; m_valid = 0;
  endtask

  task automatic model_eval();
    int km[NR];
    int id, win, k;
    bit kill, clr, sk, ov, acc;
    id   = int'(sid);
    kill = ver && mis;
    clr  = ver && !mis;
    for (int i = 0; i < NR; i++) km[i] = (int'(rmask) >> (i*CK)) & 15;
    sk  = kill && (((m_mask >> id) & 1) == 1);
    ov  = m_valid && !sk;
    acc = !m_valid || (ov && lsq) || sk;
    win = -1;
    for (int o = 0; o < NR; o++) begin
      k = (m_ptr + o) % NR;
      if (win < 0 && req[k] && !(kill && (((km[k] >> id) & 1) == 1))) win = k;
    end
    e_grant = (acc && win >= 0) ? (1 << win) : 0;
    e_ov    = ov ? 1 : 0;
    e_idx   = m_idx;
    e_mask  = m_mask;
    n_ptr = m_ptr; n_idx = m_idx; n_mask = m_mask; n_valid = m_valid;
    if (acc && win >= 0) begin
      n_valid = 1;
      n_idx   = win;
      n_mask  = clr ? (km[win] & ~(1 << id) & 15) : km[win];
      n_ptr   = (win + 1) % NR;
    end else if (acc) begin
      n_valid = 0;
    end else if (clr) begin
      n_mask = m_mask & ~(1 << id) & 15;
    end
  endtask

  // Evaluate model on current inputs and compare combinational outputs.
  task automatic settle(input string tag);
    model_eval();
    #3;
    chk({tag, ".grant"}, 32'(grant_o), 32'(e_grant));
    chk({tag, ".valid"}, 32'(outValid_o), 32'(e_ov));
    chk({tag, ".idx"}, 32'(outIdx_o), 32'(e_idx));
    chk({tag, ".mask"}, 32'(outMask_o), 32'(e_mask));
  endtask

  task automatic tick();
    @(posedge clk);
    m_ptr = n_ptr; m_idx = n_idx; m_mask = n_mask; m_valid = n_valid;
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [15:0] m, input logic l,
                       input logic v, input logic mp, input logic [1:0] id);
    req = r; rmask = m; lsq = l; ver = v; mis = mp; sid = id;
  endtask

  // Pulse reset across one clock edge; outputs must be quiet while asserted.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    chk({tag, ".rst_grant"}, 32'(grant_o), 32'(0));
    chk({tag, ".rst_valid"}, 32'(outValid_o), 32'(0));
    chk({tag, ".rst_idx"}, 32'(outIdx_o), 32'(0));
    chk({tag, ".rst_mask"}, 32'(outMask_o), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    drive(4'b1111, '0, 1'b1, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    model_reset();
    #1;
    pulse_reset("init");

    // Scenario 1: all requesting, LSQ always ready.
    drive(4'b1111, '0, 1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      settle("t1");
      chk("t1.rr_grant", 32'(grant_o), 32'(1 << (i % 4)));
      if (i > 0) chk("t1.lag_idx", 32'(outIdx_o), 32'((i - 1) % 4));
      tick();
    end

    // Scenario 2: hold while LSQ stalls, then drain and grant slot 2 together.
    pulse_reset("t2");
    drive(4'b0101, '0, 1'b0, 1'b0, 1'b0, 2'd0);
    settle("t2");
    chk("t2.first", 32'(grant_o), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle("t2h");
      chk("t2.hold_grant", 32'(grant_o), 32'h0);
      chk("t2.hold_idx", 32'(outIdx_o), 32'h0);
      chk("t2.hold_valid", 32'(outValid_o), 32'h1);
      tick();
    end
    lsq = 1'b1;
    settle("t2d");
    chk("t2.drain_grant", 32'(grant_o), 32'h4);
    tick();

    // Scenario 3: held op killed, younger-safe request granted same cycle.
    pulse_reset("t3");
    drive(4'b0100, 16'h0200, 1'b0, 1'b0, 1'b0, 2'd0);
    settle("t3a");
    tick();
    drive(4'b0001, 16'h0201, 1'b0, 1'b1, 1'b1, 2'd1);
    settle("t3b");
    chk("t3.killed", 32'(outValid_o), 32'h0);
    chk("t3.regrant", 32'(grant_o), 32'h1);
    tick();

    // Scenario 4: correct resolution clears the held checkpoint bit.
    pulse_reset("t4");
    drive(4'b0100, 16'h0200, 1'b0, 1'b0, 1'b0, 2'd0);
    settle("t4a");
    tick();
    drive(4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd1);
    settle("t4b");
    chk("t4.stays", 32'(outValid_o), 32'h1);
    tick();
    drive(4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    settle("t4c");
    chk("t4.cleared", 32'(outMask_o), 32'h0);
    chk("t4.still", 32'(outValid_o), 32'h1);
    tick();

    // Scenario 5: killed request skipped in favour of the next eligible slot.
    pulse_reset("t5");
    drive(4'b0011, 16'h0004, 1'b1, 1'b1, 1'b1, 2'd2);
    settle("t5");
    chk("t5.skip", 32'(grant_o), 32'h2);
    tick();

    // Scenario 6: async reset mid-hold with ptr=2, then restart from slot 0.
    pulse_reset("t6");
    drive(4'b0010, '0, 1'b0, 1'b0, 1'b0, 2'd0);
    settle("t6a");
    tick();
    drive(4'b1111, '0, 1'b0, 1'b0, 1'b0, 2'd0);
    #1;
    chk("t6.held", 32'(outValid_o), 32'h1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6.drop_valid", 32'(outValid_o), 32'h0);
    chk("t6.drop_grant", 32'(grant_o), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    settle("t6b");
    chk("t6.restart", 32'(grant_o), 32'h1);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom), 16'($urandom), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 3), 1'($urandom), 2'($urandom));
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rnd");
      end else begin
        settle("rnd");
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
